// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with mid-bit sampling.
//
// The raw line is passed through a two-flop synchroniser, a falling edge on
// the synchronised line opens a frame, the start bit is re-checked half a
// bit later, and the data and stop bits are sampled one bit period apart.
// A good frame is handed over through a one-entry valid/ready register.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous active-high reset
//   uart_rxd   in   raw serial line, idle high, asynchronous to clk
//   rx_data    out  received byte, held while rx_valid is high
//   rx_valid   out  byte available
//   rx_ready   in   consumer accepts the byte (transfer on valid && ready)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, new byte dropped because output was full
//   busy       out  high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 432,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int HALF  = CLKS_PER_BIT >> 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;

   logic       sync1;
   logic       rxd_s;
   logic       rxd_prev;
   // flushed[1] marks that rxd_s now carries a real line sample rather than
   // the reset value; armed marks that the line has been seen high since
   // reset, so a line that is already low at release cannot open a frame.
   logic [1:0] flushed;
   logic       armed;
   logic       fall;

   assign fall = armed & rxd_prev & ~rxd_s;

   // Synchroniser, edge-detect history and post-reset arming.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_prev <= 1'b1;
         flushed  <= 2'b00;
         armed    <= 1'b0;
      end else begin
         sync1    <= uart_rxd;
         rxd_s    <= sync1;
         rxd_prev <= rxd_s;
         flushed  <= {flushed[0], 1'b1};
         armed    <= armed | (flushed[1] & rxd_s);
      end
   end

   // Frame FSM with bit timing, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // Consumption; a delivery in the same cycle overrides this below.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     // Line back high at mid start bit: a glitch, not a frame.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_ONE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (rxd_s) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB      = 432;
   localparam int HALF     = CPB >> 1;
   // Edges from e0 (first capture of the start bit) to the stop-sample edge.
   localparam int STOP_LAT = 2 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_rxd  (uart_rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Edge counter: after a rising edge, cyc holds that edge's number.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation at the falling edge, away from the active edge.
   int         err_cnt  = 0;
   int         ovr_cnt  = 0;
   int         busy_cnt = 0;
   int         ovr_cyc  = -1;
   logic [7:0] got_q[$];
   int         rise_q[$];
   logic       prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_q.push_back(cyc);
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (overrun === 1'b1) begin
         ovr_cnt <= ovr_cnt + 1;
         ovr_cyc <= cyc;
      end
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
      prev_valid <= rx_valid;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded 90000 cycles");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(3);
   endtask

   // Line driver: start, DATA LSB first, stop held for stop_cycles.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_cycles);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         tick((i == 9) ? stop_cycles : CPB);
      end
   endtask

   task automatic test_reset();
      uart_rxd = 1'b1;
      rx_ready = 1'b0;
      reset    = 1'b1;
      tick(2);
      n_checks++;
      if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000)
         $display("FAIL reset_outputs: got %h expected 000", {rx_data, rx_valid, frame_err, overrun, busy});
      else n_pass++;
      reset = 1'b0;
      tick(5);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_basic();
      int s, r0, e0c, o0;
      uart_rxd = 1'b1;
      apply_reset();
      r0 = rise_q.size(); e0c = err_cnt; o0 = ovr_cnt;
      s = cyc;
      send_frame(8'hA5, 1'b1, CPB);
      n_checks++;
      if (rise_q.size() - r0 !== 1) $display("FAIL a5_rise_count: got %0d expected 1", rise_q.size() - r0);
      else n_pass++;
      n_checks++;
      if (((rise_q.size() > r0) ? rise_q[r0] : -1) !== s + 1 + STOP_LAT)
         $display("FAIL a5_latency: got %0d expected %0d", (rise_q.size() > r0) ? rise_q[r0] : -1, s + 1 + STOP_LAT);
      else n_pass++;
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
         $display("FAIL a5_data: got valid=%b data=%h expected valid=1 data=a5", rx_valid, rx_data);
      else n_pass++;
      n_checks++;
      if (err_cnt - e0c + ovr_cnt - o0 !== 0) $display("FAIL a5_flags: got %0d expected 0", err_cnt - e0c + ovr_cnt - o0);
      else n_pass++;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      n_checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'hA5)
         $display("FAIL a5_consume: got valid=%b data=%h expected valid=0 data=a5", rx_valid, rx_data);
      else n_pass++;
   endtask

   task automatic test_square_wave();
      int g0, r0, e0c;
      uart_rxd = 1'b1;
      apply_reset();
      rx_ready = 1'b1;
      g0 = got_q.size(); r0 = rise_q.size(); e0c = err_cnt;
      for (int i = 0; i < 21; i++) begin
         uart_rxd = (i % 2 == 0);
         tick(CPB);
      end
      uart_rxd = 1'b1;
      tick(20);
      rx_ready = 1'b0;
      n_checks++;
      if (got_q.size() - g0 !== 2) $display("FAIL sq_count: got %0d expected 2", got_q.size() - g0);
      else n_pass++;
      for (int i = g0; i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== 8'h55) $display("FAIL sq_data: got %h expected 55", got_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (((rise_q.size() >= r0 + 2) ? rise_q[r0 + 1] - rise_q[r0] : -1) !== 10 * CPB)
         $display("FAIL sq_period: got %0d expected %0d", (rise_q.size() >= r0 + 2) ? rise_q[r0 + 1] - rise_q[r0] : -1, 10 * CPB);
      else n_pass++;
      n_checks++;
      if (err_cnt - e0c !== 0) $display("FAIL sq_frame_err: got %0d expected 0", err_cnt - e0c);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int b0, r0, f0;
      uart_rxd = 1'b1;
      apply_reset();
      b0 = busy_cnt; r0 = rise_q.size(); f0 = err_cnt + ovr_cnt;
      uart_rxd = 1'b0;
      tick(100);
      uart_rxd = 1'b1;
      tick(300);
      n_checks++;
      if (busy_cnt - b0 !== HALF) $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt - b0, HALF);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", busy);
      else n_pass++;
      n_checks++;
      if ((rise_q.size() - r0) + (err_cnt + ovr_cnt - f0) !== 0)
         $display("FAIL glitch_events: got %0d expected 0", (rise_q.size() - r0) + (err_cnt + ovr_cnt - f0));
      else n_pass++;
   endtask

   task automatic test_frame_error();
      int b1, r0, e0c;
      uart_rxd = 1'b1;
      apply_reset();
      r0 = rise_q.size(); e0c = err_cnt;
      send_frame(8'h3C, 1'b0, CPB);
      b1 = busy_cnt;
      tick(2000);
      n_checks++;
      if (busy_cnt - b1 !== 0) $display("FAIL ferr_held_low_busy: got %0d expected 0", busy_cnt - b1);
      else n_pass++;
      uart_rxd = 1'b1;
      tick(50);
      n_checks++;
      if (err_cnt - e0c !== 1) $display("FAIL ferr_pulse: got %0d expected 1", err_cnt - e0c);
      else n_pass++;
      n_checks++;
      if (rx_valid !== 1'b0 || rise_q.size() - r0 !== 0)
         $display("FAIL ferr_no_data: got valid=%b rises=%0d expected 0 0", rx_valid, rise_q.size() - r0);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int s1, o0, e0c, g0, tgt;
      uart_rxd = 1'b1;
      apply_reset();
      o0 = ovr_cnt; e0c = err_cnt;
      s1 = cyc;
      send_frame(8'h12, 1'b1, CPB);
      send_frame(8'h34, 1'b1, CPB);
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h12)
         $display("FAIL ovr_keep_old: got valid=%b data=%h expected valid=1 data=12", rx_valid, rx_data);
      else n_pass++;
      n_checks++;
      if (ovr_cnt - o0 !== 1 || err_cnt - e0c !== 0)
         $display("FAIL ovr_pulse: got ovr=%0d err=%0d expected 1 0", ovr_cnt - o0, err_cnt - e0c);
      else n_pass++;
      n_checks++;
      if (ovr_cyc !== s1 + 10 * CPB + 1 + STOP_LAT)
         $display("FAIL ovr_timing: got %0d expected %0d", ovr_cyc, s1 + 10 * CPB + 1 + STOP_LAT);
      else n_pass++;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      n_checks++;
      if (rx_valid !== 1'b0) $display("FAIL ovr_consume: got %b expected 0", rx_valid);
      else n_pass++;

      // Same pair, with the consumer accepting exactly at the second stop sample.
      apply_reset();
      o0 = ovr_cnt; g0 = got_q.size();
      s1 = cyc;
      tgt = s1 + 10 * CPB + STOP_LAT;
      fork
         begin
            send_frame(8'h12, 1'b1, CPB);
            send_frame(8'h34, 1'b1, CPB);
         end
         begin
            while (cyc < tgt) tick(1);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h34)
               $display("FAIL ovr_same_cycle_load: got valid=%b data=%h expected valid=1 data=34", rx_valid, rx_data);
            else n_pass++;
         end
      join
      n_checks++;
      if (ovr_cnt - o0 !== 0) $display("FAIL ovr_same_cycle_flag: got %0d expected 0", ovr_cnt - o0);
      else n_pass++;
      n_checks++;
      if (((got_q.size() == g0 + 1) ? got_q[g0] : 8'hxx) !== 8'h12)
         $display("FAIL ovr_same_cycle_taken: got count=%0d expected one byte 12", got_q.size() - g0);
      else n_pass++;
   endtask

   // Starts with a byte still held in the output register from the previous test.
   task automatic test_reset_midframe();
      int b0, r0, f0, s;
      uart_rxd = 1'b0;
      tick(CPB);
      uart_rxd = 1'b1;
      tick(4 * CPB + 200);
      n_checks++;
      if (busy !== 1'b1 || rx_valid !== 1'b1)
         $display("FAIL rst_pre: got busy=%b valid=%b expected 1 1", busy, rx_valid);
      else n_pass++;
      #2;
      reset    = 1'b1;
      uart_rxd = 1'b0;
      #1;
      n_checks++;
      if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000)
         $display("FAIL rst_immediate: got %h expected 000", {rx_data, rx_valid, frame_err, overrun, busy});
      else n_pass++;
      @(posedge clk);
      #1;
      tick(2);
      reset = 1'b0;
      b0 = busy_cnt; r0 = rise_q.size(); f0 = err_cnt + ovr_cnt;
      tick(1000);
      n_checks++;
      if (busy_cnt - b0 !== 0 || rise_q.size() - r0 !== 0)
         $display("FAIL rst_low_line: got busy=%0d rises=%0d expected 0 0", busy_cnt - b0, rise_q.size() - r0);
      else n_pass++;
      uart_rxd = 1'b1;
      tick(500);
      s = cyc;
      send_frame(8'h81, 1'b1, CPB);
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h81)
         $display("FAIL rst_next_frame: got valid=%b data=%h expected valid=1 data=81", rx_valid, rx_data);
      else n_pass++;
      n_checks++;
      if (((rise_q.size() == r0 + 1) ? rise_q[r0] : -1) !== s + 1 + STOP_LAT || err_cnt + ovr_cnt - f0 !== 0)
         $display("FAIL rst_next_timing: got rises=%0d flags=%0d expected one rise at %0d and 0 flags",
                  rise_q.size() - r0, err_cnt + ovr_cnt - f0, s + 1 + STOP_LAT);
      else n_pass++;
   endtask

   // Random bytes and stop bits against a frame-level model: a high stop bit
   // delivers the byte, a low one yields exactly one frame error.
   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      logic       stop;
      int         g0, e0c, o0, exp_err, n;
      uart_rxd = 1'b1;
      apply_reset();
      rx_ready = 1'b1;
      g0 = got_q.size(); e0c = err_cnt; o0 = ovr_cnt; exp_err = 0;
      for (int k = 0; k < 4; k++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         send_frame(d, stop, CPB);
         if (stop) exp_q.push_back(d);
         else exp_err++;
         uart_rxd = 1'b1;
         tick($urandom_range(5, 60));
      end
      tick(30);
      rx_ready = 1'b0;
      n_checks++;
      if (got_q.size() - g0 !== exp_q.size())
         $display("FAIL rand_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
      else n_pass++;
      n = (got_q.size() - g0 < exp_q.size()) ? got_q.size() - g0 : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (got_q[g0 + i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[g0 + i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (err_cnt - e0c !== exp_err || ovr_cnt - o0 !== 0)
         $display("FAIL rand_flags: got err=%0d ovr=%0d expected err=%0d ovr=0", err_cnt - e0c, ovr_cnt - o0, exp_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_square_wave();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that sits directly upstream of the `uart_test` logic and is fed straight from the `uart_rxd` pin. It synchronises the asynchronous line and frames 8N1 characters with mid-bit sampling. Each received byte is presented on a one-entry valid/ready output register. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 432: clock cycles per bit period; must be ≥ 4. `HALF` = `CLKS_PER_BIT >> 1`.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; all registers clear immediately on assertion.
- `uart_rxd`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  received byte, stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts; transfer when `rx_valid` && `rx_ready`.
- `frame_err`  out  1  1-cycle pulse: stop bit sampled low.
- `overrun`  out  1  1-cycle pulse: new byte dropped because the output register was still full.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Input path: 2-flop synchroniser producing `rxd_s`, plus a registered `rxd_prev`. All three reset to 1.
- FSM states are IDLE, START, DATA, STOP. It uses `cnt` (wide enough for `CLKS_PER_BIT`-1), `bit_idx` and a shift register `shreg`.
- IDLE: a falling edge (`rxd_prev`=1, `rxd_s`=0) moves to START with `cnt`=0. A held-low line never starts a frame.
- START: increment `cnt`. When `cnt`==`HALF`-1, sample `rxd_s`.
  - Sample 0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - Sample 1: treat as a glitch and return to IDLE with no flag.
- DATA: increment `cnt`. When `cnt`==`CLKS_PER_BIT`-1, shift `rxd_s` into the MSB of `shreg` (right shift) and set `cnt`=0.
  - After sampling bit `DATA_BITS`-1, go to STOP.
- STOP: when `cnt`==`CLKS_PER_BIT`-1, sample `rxd_s` and return to IDLE.
  - Sample 1: deliver `shreg`.
  - Sample 0: pulse `frame_err` and discard the byte.
- Delivery (at the STOP sample edge):
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - If `rx_valid`=1 and `rx_ready`=0: keep the old byte and pulse `overrun`.
- Consumption: `rx_valid` && `rx_ready` with no simultaneous load clears `rx_valid` at that edge.
- `rx_data` keeps its last value when `rx_valid`=0.
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. FSM is IDLE and the synchroniser is 1.
- Reset mid-frame aborts the frame with no flags and no delivery. After release, a line that is already low does not start a frame until it goes high and then low again.

## Timing
- Let e0 be the first `clk` edge at which the synchroniser's first flop captures `uart_rxd`=0.
  - FSM enters START at e0+2.
  - Start-bit sample is at e0+2+`HALF`.
  - Data bit k is sampled at e0+2+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop-bit sample is at e0+2+`HALF`+9·`CLKS_PER_BIT`.
- `rx_valid`, `frame_err` and `overrun` are registered at the stop-sample edge. At defaults this is 4106 cycles after e0.
- A new falling edge is accepted from the first cycle after returning to IDLE. Back-to-back frames with one stop bit are received without loss.
- `frame_err` and `overrun` are each high for exactly one cycle. They are mutually exclusive per frame.
- Sample-point error is at most ±1 cycle, plus synchroniser delay.

## Test plan
- Send 0xA5 (8N1, 432 clk/bit) with `rx_ready`=0 -> `rx_valid` rises 4106 cycles after e0, `rx_data`=0xA5, no flags. Then `rx_ready`=1 for one cycle -> `rx_valid`=0 on the next cycle.
- Square wave on `uart_rxd` toggling every 432 cycles from reset release -> consecutive 0x55 frames. With `rx_ready`=1 there is one `rx_valid` pulse per 4320 cycles and `frame_err`=0.
- Low glitch of 100 cycles (< `HALF`) -> `busy` high then back to 0, no `rx_valid`, no flags.
- Frame 0x3C with stop bit driven 0, then the line held low 2000 cycles before going high -> one `frame_err` pulse, `rx_valid`=0, and no new frame while the line is held low.
- Bytes 0x12 then 0x34 back-to-back with `rx_ready`=0 -> `rx_data`=0x12 and a single `overrun` pulse at the second stop sample. Repeat with `rx_ready`=1 exactly in the cycle of the second stop sample -> `rx_valid` stays 1, `rx_data`=0x34, no `overrun`.
- Assert `reset` during data bit 4 of 0xFF -> all outputs 0 immediately. After release with the line already low, nothing is received. A following clean 0x81 frame is received correctly.
